// File: rtl/sample_operand_loader.sv
// Byte-stream to operand-triple loader with a one-deep output slot and a precomputed a/b/else priority code.
// Optional idle timeout for partial triples is enabled by defining LOADER_TIMEOUT_EN.
module sample_operand_loader #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sync_clr,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic [7:0] c,
    output logic [1:0] sel,
    output logic [7:0] triple_cnt,
    output logic       err
);

    typedef enum logic [1:0] {S_A, S_B, S_C, S_HOLD} state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
    } triple_t;

    state_t     state, state_n;
    logic [7:0] ra, rb, rc;
    logic       acc, dlv, load, expire;
    triple_t    load_val;

    function automatic logic [1:0] prio(input triple_t t);
        if (t.a != 8'd0)      return 2'd1;
        else if (t.b != 8'd0) return 2'd2;
        else                  return 2'd3;
    endfunction

    assign in_ready = (state != S_HOLD);
    assign acc      = in_valid && in_ready;
    assign dlv      = out_valid && out_ready;

`ifdef LOADER_TIMEOUT_EN
    logic [7:0] idle_cnt;
    logic       idle_hit;
    assign idle_hit = (idle_cnt == 8'(TIMEOUT - 1));
`else
    logic       idle_hit;
    logic       unused_tmo;
    assign idle_hit   = 1'b0;
    assign unused_tmo = ^8'(TIMEOUT);
`endif

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        expire   = 1'b0;
        load_val = '{a: ra, b: rb, c: in_data};
        case (state)
            S_A: if (acc) state_n = S_B;
            S_B: if (acc) state_n = S_C;
            S_C: begin
                if (acc) begin
                    // Slot free or emptying this edge: load straight through, no bubble
                    if (!out_valid || out_ready) begin
                        load    = 1'b1;
                        state_n = S_A;
                    end else begin
                        state_n = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                load_val = '{a: ra, b: rb, c: rc};
                if (dlv) begin
                    load    = 1'b1;
                    state_n = S_A;
                end
            end
            default: state_n = S_A;
        endcase
        if ((state == S_B || state == S_C) && !acc && idle_hit) begin
            expire  = 1'b1;
            state_n = S_A;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        state <= S_A;
        else if (sync_clr) state <= S_A;
        else               state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra <= '0;
            rb <= '0;
            rc <= '0;
        end else if (sync_clr) begin
            ra <= '0;
            rb <= '0;
            rc <= '0;
        end else if (acc) begin
            case (state)
                S_A:     ra <= in_data;
                S_B:     rb <= in_data;
                S_C:     rc <= in_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            a          <= '0;
            b          <= '0;
            c          <= '0;
            sel        <= 2'd3;
            triple_cnt <= '0;
        end else if (sync_clr) begin
            out_valid  <= 1'b0;
            a          <= '0;
            b          <= '0;
            c          <= '0;
            sel        <= 2'd3;
            triple_cnt <= '0;
        end else begin
            if (dlv) triple_cnt <= triple_cnt + 8'd1;
            if (load) begin
                out_valid <= 1'b1;
                a         <= load_val.a;
                b         <= load_val.b;
                c         <= load_val.c;
                sel       <= prio(load_val);
            end else if (dlv) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef LOADER_TIMEOUT_EN
    // Idle count only matters mid-collection; S_A and S_HOLD keep it parked at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            err      <= 1'b0;
        end else if (sync_clr) begin
            idle_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= expire;
            if (acc || expire || state_n == S_A || state == S_HOLD)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 8'd1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sample_operand_loader.sv
// Directed bench for sample_operand_loader: reset, priority decode, streaming, backpressure, wrap/clear, timeout.
module tb_sample_operand_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sync_clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] a, b, c;
    logic [1:0] sel;
    logic [7:0] triple_cnt;
    logic       err;

    int total = 0;
    int bad = 0;

    sample_operand_loader #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .c(c), .sel(sel),
        .triple_cnt(triple_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) chk("push_timeout", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic deliver();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic prio_case(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                             input int exp_sel);
        push(x); push(y); push(z);
        chk("prio_valid", 32'(out_valid), 1);
        chk("prio_sel", 32'(sel), exp_sel);
        chk("prio_b", 32'(b), 32'(y));
        deliver();
    endtask

    initial begin
        int dl_cnt, stall, first_dl, last_dl, gap_bad, errs;

        // reset state
        step();
        rst_n = 1'b1;
        step();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_sel", 32'(sel), 3);
        chk("rst_cnt", 32'(triple_cnt), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_err", 32'(err), 0);

        // reset mid-collection drops the partial triple
        push('hAA); push('hBB);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        chk("rst2_valid", 32'(out_valid), 0);
        chk("rst2_sel", 32'(sel), 3);
        chk("rst2_ready", 32'(in_ready), 1);
        push('h01); push('h02); push('h03);
        chk("lat_valid", 32'(out_valid), 1);
        chk("lat_a", 32'(a), 'h01);
        chk("lat_b", 32'(b), 'h02);
        chk("lat_c", 32'(c), 'h03);
        chk("lat_sel", 32'(sel), 1);
        deliver();
        chk("dl_valid", 32'(out_valid), 0);
        chk("dl_cnt", 32'(triple_cnt), 1);
        chk("dl_hold_a", 32'(a), 'h01);

        // priority decode
        prio_case('h00, 'h05, 'h09, 2);
        prio_case('h00, 'h00, 'h00, 3);
        prio_case('h80, 'h00, 'h00, 1);
        chk("prio_cnt", 32'(triple_cnt), 4);

        // clear, then stream 12 bytes with out_ready held high
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        chk("clr_cnt", 32'(triple_cnt), 0);
        out_ready = 1'b1;
        dl_cnt = 0; stall = 0; first_dl = -1; last_dl = -1; gap_bad = 0;
        for (int i = 0; i < 13; i++) begin
            in_valid = (i < 12);
            in_data  = 8'(8'h10 + i);
            if (i < 12 && !in_ready) stall++;
            if (out_valid) begin
                if (first_dl < 0) first_dl = i;
                else if (i - last_dl != 3) gap_bad++;
                last_dl = i;
                dl_cnt++;
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("str_stall", 32'(stall), 0);
        chk("str_dl", 32'(dl_cnt), 4);
        chk("str_first", 32'(first_dl), 3);
        chk("str_gap", 32'(gap_bad), 0);
        chk("str_cnt", 32'(triple_cnt), 4);
        chk("str_a", 32'(a), 'h19);
        chk("str_c", 32'(c), 'h1B);
        chk("str_valid", 32'(out_valid), 0);

        // backpressure: second triple parks in the collection registers
        push('h21); push('h22); push('h23);
        push('h24); push('h25); push('h26);
        chk("bp_ready", 32'(in_ready), 0);
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_a", 32'(a), 'h21);
        step(); step();
        chk("bp_stable_a", 32'(a), 'h21);
        chk("bp_stable_c", 32'(c), 'h23);
        chk("bp_still", 32'(in_ready), 0);
        deliver();
        chk("bp2_valid", 32'(out_valid), 1);
        chk("bp2_a", 32'(a), 'h24);
        chk("bp2_b", 32'(b), 'h25);
        chk("bp2_c", 32'(c), 'h26);
        chk("bp2_ready", 32'(in_ready), 1);
        chk("bp2_cnt", 32'(triple_cnt), 5);
        deliver();
        chk("bp3_cnt", 32'(triple_cnt), 6);

        // 250 more deliveries: 256 total wraps the counter to 0
        out_ready = 1'b1;
        for (int i = 0; i < 751; i++) begin
            in_valid = (i < 750);
            in_data  = 8'(i);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("wrap_cnt", 32'(triple_cnt), 0);
        chk("wrap_valid", 32'(out_valid), 0);

        push('h41); push('h42); push('h43);
        chk("clr_pre", 32'(out_valid), 1);
        sync_clr = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        sync_clr = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("clr_valid", 32'(out_valid), 0);
        chk("clr_sel", 32'(sel), 3);
        chk("clr_a", 32'(a), 0);
        chk("clr_cnt2", 32'(triple_cnt), 0);
        chk("clr_ready", 32'(in_ready), 1);

        // partial triple left idle
        push('h77);
        errs = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (err) errs++;
        end
`ifdef LOADER_TIMEOUT_EN
        chk("tmo_err", 32'(errs), 1);
        push('h31); push('h32);
        chk("tmo_partial", 32'(out_valid), 0);
        push('h33);
        chk("tmo_valid", 32'(out_valid), 1);
        chk("tmo_a", 32'(a), 'h31);
        chk("tmo_b", 32'(b), 'h32);
        chk("tmo_c", 32'(c), 'h33);
`else
        chk("tmo_err", 32'(errs), 0);
        push('h32); push('h33);
        chk("tmo_valid", 32'(out_valid), 1);
        chk("tmo_a", 32'(a), 'h77);
        chk("tmo_b", 32'(b), 'h32);
        chk("tmo_c", 32'(c), 'h33);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_operand_loader.md
# sample_operand_loader

Upstream feeder for the `sample` register block. It accepts a byte stream over a valid/ready handshake and groups every three accepted bytes into an operand triple `a`, `b`, `c`. It then presents the triple on registered outputs, together with a precomputed 2-bit priority code that matches the downstream `a`/`b`/else decode. One triple can be held at the output while the next is being collected, so the upstream stream stalls only when both slots are full.

## Interface
- `TIMEOUT`, default 255: idle-cycle limit for a partially collected triple; legal range 1..255. Used only when `LOADER_TIMEOUT_EN` is defined.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sync_clr`  in  1  synchronous clear; same effect as reset, applied at the clock edge.
- `in_valid`  in  1  upstream byte valid.
- `in_ready`  out  1  loader can accept a byte.
- `in_data`  in  8  upstream byte.
- `out_valid`  out  1  triple available on `a`, `b`, `c`.
- `out_ready`  in  1  downstream consumes the triple.
- `a`  out  8  first byte of the triple.
- `b`  out  8  second byte of the triple.
- `c`  out  8  third byte of the triple.
- `sel`  out  2  priority code: 1 if `a`≠0, else 2 if `b`≠0, else 3.
- `triple_cnt`  out  8  count of delivered triples; wraps 255→0.
- `err`  out  1  one-cycle pulse when a partial triple is discarded by timeout.

## Operation
- A byte is accepted when `in_valid` and `in_ready` are both high at the edge. A triple is delivered when `out_valid` and `out_ready` are both high at the edge.
- The collection state machine has four states:
  - S_A: accepted byte → collection register A; go to S_B.
  - S_B: accepted byte → collection register B; go to S_C.
  - S_C: accepted byte → collection register C. If the output slot is free, or is being delivered this same cycle, copy A/B/{accepted byte} to the output registers, set `out_valid`, and go to S_A. Otherwise go to S_HOLD.
  - S_HOLD: no bytes accepted. On delivery, copy the collection registers to the output registers, keep `out_valid` high, and go to S_A.
- `in_ready` is 1 in S_A, S_B and S_C, and 0 in S_HOLD.
- If a delivery occurs with no new triple ready to load, `out_valid` goes to 0.
- `a`, `b`, `c` and `sel` are registered. `sel` is computed from the value being loaded into the output registers. They change only on an output load and hold their value while `out_valid` is low.
- `triple_cnt` increments on each delivery.
- Reset and `sync_clr` values:
  - state = S_A.
  - `out_valid` = 0, `a` = `b` = `c` = 0, `sel` = 3, `triple_cnt` = 0, `err` = 0.
  - Collection registers = 0.
  - `in_ready` = 1 after reset is released.
- A partial triple present at reset or `sync_clr` is lost. `sync_clr` overrides any handshake in the same cycle.

## Timing
- Latency: if the third byte is accepted at edge N into a free output slot, `out_valid` is 1 after edge N with the new `a`/`b`/`c`/`sel` already valid.
- Back-to-back: with `out_ready` held at 1 and a continuous input stream, the loader sustains one byte per cycle and one triple per 3 cycles with no stall.
- Blocked output: once the second triple completes while the first is still undelivered, `in_ready` is 0 starting the cycle after that third byte is accepted. It returns to 1 the cycle after the delivery edge.
- Simultaneous third-byte accept and delivery in S_C: the new triple replaces the delivered one, `out_valid` stays 1, and there is no bubble.
- `out_valid` must not drop without a delivery. `a`/`b`/`c` must stay stable while `out_valid`=1 and `out_ready`=0.
- `in_data` is sampled only on an accept edge.

## Configuration
- `LOADER_TIMEOUT_EN` defined:
  - An 8-bit idle counter runs in S_B and S_C. It clears on every accepted byte and on every entry to S_A.
  - When the counter reaches `TIMEOUT` with no accept, the partial triple is discarded, state goes to S_A, and `err` pulses for exactly one cycle.
  - The output slot is unaffected.
  - An accept on the same cycle the counter would expire wins: no discard and no `err`.
- `LOADER_TIMEOUT_EN` undefined: no idle counter, partial triples wait indefinitely, `err` is tied to 0, and `TIMEOUT` is ignored.

## Test plan
- Reset: assert `rst_n`=0 mid-collection after 2 bytes, then release. Required: `out_valid`=0, `sel`=3, `triple_cnt`=0, `in_ready`=1. The next 3 bytes 0x01, 0x02, 0x03 give `a`=0x01, `b`=0x02, `c`=0x03.
- Priority: send the triple 0x00, 0x05, 0x09 → `sel`=2. Send 0x00, 0x00, 0x00 → `sel`=3. Send 0x80, 0x00, 0x00 → `sel`=1.
- Streaming: hold `out_ready`=1 and send 12 bytes continuously. Required: `in_ready` never drops, 4 triples are delivered 3 cycles apart, and `triple_cnt`=4.
- Backpressure: hold `out_ready`=0 and send 6 bytes. `in_ready`=0 after the 6th accept and the first triple stays stable. Raise `out_ready` for one cycle. Required: the second triple appears with `out_valid` still 1, and `in_ready`=1 on the next cycle.
- Wrap and clear: deliver 256 triples → `triple_cnt` reads 0. Pulse `sync_clr` while `out_valid`=1 → `out_valid`=0 on the next cycle.
- Timeout (macro on, `TIMEOUT`=4): send 1 byte, then idle for 4 cycles. Required: `err` is high for 1 cycle, and the next 3 bytes form a complete fresh triple. With the macro off, the same stimulus gives `err`=0 and the next 2 bytes complete the triple.
